fp_addsub_pipe: RTL

//  Pipelined single-precision add/subtract front end for the FFT butterfly datapath.
//  - Resolves the effective operation from op_sub and the operand signs.
//  - Routes same-sign magnitudes to sradd and opposite-sign magnitudes to srsub.

---
 rtl/fp_addsub_pipe.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// Module   : fp_addsub_pipe
// Brief    : Two-stage single-precision add/subtract front end with a
//            valid/ready handshake. It steers same-sign operand pairs to
//            sradd and opposite-sign pairs to srsub. The optional build
//            macro FP_ADDSUB_STATS_EN adds saturating operation and NaN
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_pipe #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      z,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      op_count,
  output logic [15:0]      nan_count
);

  localparam logic [31:0] NAN_WORD = 32'hFFFF_FFFF;

  // Magnitude add of two same-sign operands. The result is truncated, and
  // an exponent overflow saturates to infinity.
  function automatic logic [31:0] sradd(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  ex, ey, eb, es, d;
    logic [26:0] mx, my, mb, ms;
    logic [27:0] sum;
    logic [8:0]  e;
    logic [31:0] r;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    if ({ex, mx} >= {ey, my}) begin
      eb = ex; mb = mx; es = ey; ms = my;
    end else begin
      eb = ey; mb = my; es = ex; ms = mx;
    end
    d   = eb - es;
    ms  = (d > 8'd26) ? 27'd0 : (ms >> d);
    sum = {1'b0, mb} + {1'b0, ms};
    e   = {1'b0, eb};
    if (sum[27]) begin
      sum = sum >> 1;
      e   = e + 9'd1;
    end
    if (e >= 9'd255)
      r = {x[31], 8'hFF, 23'd0};
    else if (!sum[26])
      r = {x[31], 8'd0, sum[25:3]};
    else
      r = {x[31], e[7:0], sum[25:3]};
    return r;
  endfunction

  // x - y for two operands of equal sign. Equal operands give +0. A result
  // below the normal range becomes denormal.
  function automatic logic [31:0] srsub(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]  ex, ey, eb, es, d;
    logic [26:0] mx, my, mb, ms, diff, norm;
    logic [4:0]  lz;
    logic        found, sgn;
    logic [31:0] r;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    if ({ex, mx} > {ey, my}) begin
      eb = ex; mb = mx; es = ey; ms = my; sgn = x[31];
    end else begin
      eb = ey; mb = my; es = ex; ms = mx; sgn = ~x[31];
    end
    d     = eb - es;
    ms    = (d > 8'd26) ? 27'd0 : (ms >> d);
    diff  = mb - ms;
    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (diff[i]) found = 1'b1;
        else         lz    = lz + 5'd1;
      end
    end
    if ({ex, mx} == {ey, my}) begin
      norm = 27'd0;
      r    = 32'd0;
    end else if ({3'd0, lz} < eb) begin
      norm = diff << lz;
      r    = {sgn, eb - {3'd0, lz}, norm[25:3]};
    end else begin
      norm = diff << (eb - 8'd1);
      r    = {sgn, 8'd0, norm[25:3]};
    end
    return r;
  endfunction

  logic             s1_valid_q, s1_same_q, s1_nan_q;
  logic [31:0]      s1_a_q, s1_be_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_valid_q;
  logic [31:0]      z_q;
  logic [TAG_W-1:0] out_tag_q;

  logic        s1_adv, s1_load;
  logic [31:0] be_d, z_d;
  logic        same_d, nan_d;

  assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s1_adv;
  assign s1_load  = in_valid & in_ready;

  assign be_d   = op_sub ? {~b[31], b[30:0]} : b;
  assign same_d = (a[31] == be_d[31]);
  // The NaN check uses the raw b, because be may have its sign bit flipped.
  assign nan_d  = (a == NAN_WORD) | (b == NAN_WORD);

  always_comb begin
    z_d = 32'd0;
    if (s1_nan_q)
      z_d = NAN_WORD;
    else if (s1_a_q == 32'd0)
      z_d = s1_be_q;
    else if (s1_be_q[30:0] == 31'd0)
      z_d = s1_a_q;
    else if (s1_same_q)
      z_d = sradd(s1_a_q, s1_be_q);
    else
      z_d = srsub(s1_a_q, {~s1_be_q[31], s1_be_q[30:0]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= 32'd0;
      s1_be_q     <= 32'd0;
      s1_same_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 32'd0;
      out_tag_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_a_q    <= a;
        s1_be_q   <= be_d;
        s1_same_q <= same_d;
        s1_nan_q  <= nan_d;
        s1_tag_q  <= in_tag;
      end
      if (s1_load)
        s1_valid_q <= 1'b1;
      else if (s1_adv)
        s1_valid_q <= 1'b0;
      if (s1_adv) begin
        out_valid_q <= 1'b1;
        z_q         <= z_d;
        out_tag_q   <= s1_tag_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign out_tag   = out_tag_q;

`ifdef FP_ADDSUB_STATS_EN
  logic [15:0] op_count_q, nan_count_q;
  logic        out_xfer;

  assign out_xfer = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_q  <= 16'd0;
      nan_count_q <= 16'd0;
    end else if (out_xfer) begin
      if (op_count_q != 16'hFFFF)
        op_count_q <= op_count_q + 16'd1;
      if ((z_q == NAN_WORD) && (nan_count_q != 16'hFFFF))
        nan_count_q <= nan_count_q + 16'd1;
    end
  end

  assign op_count  = op_count_q;
  assign nan_count = nan_count_q;
`else
  assign op_count  = 16'd0;
  assign nan_count = 16'd0;
`endif

endmodule

`default_nettype wire
